// File: rtl/ast_width_reducer_pkg.sv
// Shared types and the last-word helper for the Avalon-ST width reducer.
package ast_width_reducer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  typedef struct packed {
    int last_idx;
    int last_empty;
  } last_info_t;

  // Index of the final narrow word and its empty count for one wide beat.
  // Non-EOP beats are always full, whatever sink_empty carries.
  function automatic last_info_t calc_last(input logic eop, input int empty,
                                           input int in_bytes, input int out_bytes);
    last_info_t info;
    int         vb;
    vb              = eop ? (in_bytes - empty) : in_bytes;
    info.last_idx   = (vb + out_bytes - 1) / out_bytes - 1;
    info.last_empty = (out_bytes - (vb % out_bytes)) % out_bytes;
    return info;
  endfunction

endpackage

// File: rtl/ast_width_reducer.sv
// Avalon-ST width down-converter: one wide sink beat becomes up to RATIO narrow words.
// Optional AST_WIDTH_REDUCER_PROTO_CHECK_EN adds a sticky proto_err output.
module ast_width_reducer
  import ast_width_reducer_pkg::*;
#(
  parameter int DATA_IN_W   = 256,
  parameter int DATA_OUT_W  = 64,
  parameter int CHANNEL_W   = 10,
  parameter int EMPTY_IN_W  = (DATA_IN_W / 8 > 1) ? $clog2(DATA_IN_W / 8) : 1,
  parameter int EMPTY_OUT_W = (DATA_OUT_W / 8 > 1) ? $clog2(DATA_OUT_W / 8) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_IN_W-1:0]   sink_data,
  input  logic                   sink_startofpacket,
  input  logic                   sink_endofpacket,
  input  logic                   sink_valid,
  input  logic [EMPTY_IN_W-1:0]  sink_empty,
  input  logic [CHANNEL_W-1:0]   sink_channel,
  output logic                   sink_ready,
  output logic [DATA_OUT_W-1:0]  source_data,
  output logic                   source_startofpacket,
  output logic                   source_endofpacket,
  output logic                   source_valid,
  output logic [EMPTY_OUT_W-1:0] source_empty,
  output logic [CHANNEL_W-1:0]   source_channel,
  input  logic                   source_ready
`ifdef AST_WIDTH_REDUCER_PROTO_CHECK_EN
  ,
  output logic                   proto_err
`endif
);

  localparam int RATIO     = DATA_IN_W / DATA_OUT_W;
  localparam int IDX_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int IN_BYTES  = DATA_IN_W / 8;
  localparam int OUT_BYTES = DATA_OUT_W / 8;

  state_t                 r_state, w_next_state;
  logic                   r_run;
  logic [IDX_W-1:0]       r_idx, w_next_idx;
  logic [DATA_IN_W-1:0]   r_hold;
  logic                   r_sop, r_eop;
  logic [CHANNEL_W-1:0]   r_chan;
  logic [IDX_W-1:0]       r_last_idx;
  logic [EMPTY_OUT_W-1:0] r_last_empty;

  last_info_t w_info;
  logic       w_unused;
  logic       w_send, w_last, w_sink_hs, w_src_hs;

  assign w_info   = calc_last(sink_endofpacket, int'(sink_empty), IN_BYTES, OUT_BYTES);
  assign w_unused = &{1'b0, w_info.last_idx[31:IDX_W], w_info.last_empty[31:EMPTY_OUT_W]};

  assign w_send    = (r_state == SEND);
  assign w_last    = (r_idx == r_last_idx);
  // r_run keeps sink_ready low through reset and for the first cycle after release.
  assign sink_ready = r_run && (!w_send || (source_ready && w_last));
  assign w_sink_hs  = sink_valid && sink_ready;
  assign w_src_hs   = w_send && source_ready;

  // FSM state and word index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
      r_run   <= 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    case (r_state)
      IDLE: begin
        if (w_sink_hs) begin
          w_next_state = SEND;
          w_next_idx   = '0;
        end
      end
      SEND: begin
        if (w_src_hs) begin
          if (!w_last) begin
            w_next_idx = r_idx + 1'b1;
          end else if (w_sink_hs) begin
            w_next_idx = '0;
          end else begin
            w_next_state = IDLE;
            w_next_idx   = '0;
          end
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_idx   = '0;
      end
    endcase
  end

  // Hold register: payload is only observed while in SEND, so it needs no reset
  always_ff @(posedge clk) begin
    if (w_sink_hs) begin
      r_hold       <= sink_data;
      r_sop        <= sink_startofpacket;
      r_eop        <= sink_endofpacket;
      r_chan       <= sink_channel;
      r_last_idx   <= w_info.last_idx[IDX_W-1:0];
      r_last_empty <= w_info.last_empty[EMPTY_OUT_W-1:0];
    end
  end

  // Output mux: first symbol sits in the MSBs, so word 0 is the top slice
  assign source_valid         = w_send;
  assign source_data          = w_send ? r_hold[DATA_IN_W-1 - int'(r_idx)*DATA_OUT_W -: DATA_OUT_W] : '0;
  assign source_startofpacket = w_send && r_sop && (r_idx == '0);
  assign source_endofpacket   = w_send && r_eop && w_last;
  assign source_empty         = (w_send && r_eop && w_last) ? r_last_empty : '0;
  assign source_channel       = w_send ? r_chan : '0;

`ifdef AST_WIDTH_REDUCER_PROTO_CHECK_EN
  logic r_open;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_open    <= 1'b0;
      proto_err <= 1'b0;
    end else if (w_sink_hs) begin
      r_open <= !sink_endofpacket;
      if ((sink_startofpacket && r_open) || (!sink_startofpacket && !r_open) ||
          (!sink_endofpacket && (sink_empty != '0))) begin
        proto_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ast_width_reducer.sv
// Directed self-checking bench for ast_width_reducer (256 -> 64 bits, 10-bit channel).
module tb_ast_width_reducer;

  localparam int DIW = 256;
  localparam int DOW = 64;
  localparam int CW  = 10;
  localparam int EIW = 5;
  localparam int EOW = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [DIW-1:0] sink_data = '0;
  logic           sink_startofpacket = 1'b0;
  logic           sink_endofpacket = 1'b0;
  logic           sink_valid = 1'b0;
  logic [EIW-1:0] sink_empty = '0;
  logic [CW-1:0]  sink_channel = '0;
  logic           sink_ready;
  logic [DOW-1:0] source_data;
  logic           source_startofpacket;
  logic           source_endofpacket;
  logic           source_valid;
  logic [EOW-1:0] source_empty;
  logic [CW-1:0]  source_channel;
  logic           source_ready = 1'b0;
`ifdef AST_WIDTH_REDUCER_PROTO_CHECK_EN
  logic           proto_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ast_width_reducer #(.DATA_IN_W(DIW), .DATA_OUT_W(DOW), .CHANNEL_W(CW)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .sink_data            (sink_data),
    .sink_startofpacket   (sink_startofpacket),
    .sink_endofpacket     (sink_endofpacket),
    .sink_valid           (sink_valid),
    .sink_empty           (sink_empty),
    .sink_channel         (sink_channel),
    .sink_ready           (sink_ready),
    .source_data          (source_data),
    .source_startofpacket (source_startofpacket),
    .source_endofpacket   (source_endofpacket),
    .source_valid         (source_valid),
    .source_empty         (source_empty),
    .source_channel       (source_channel),
    .source_ready         (source_ready)
`ifdef AST_WIDTH_REDUCER_PROTO_CHECK_EN
    ,
    .proto_err            (proto_err)
`endif
  );

  // {valid, sop, eop, empty, channel, data, sink_ready}
  logic [80:0] obs;
  assign obs = {source_valid, source_startofpacket, source_endofpacket, source_empty,
                source_channel, source_data, sink_ready};

  // Byte k of the beat is seed+k; byte 0 lands in the MSBs.
  function automatic logic [DIW-1:0] mk_data(input logic [7:0] seed);
    logic [DIW-1:0] d = '0;
    for (int k = 0; k < DIW / 8; k++) d = {d[DIW-9:0], 8'(seed + 8'(k))};
    return d;
  endfunction

  function automatic logic [DOW-1:0] exp_bytes(input logic [7:0] seed, input int w);
    logic [DOW-1:0] e = '0;
    for (int b = 0; b < 8; b++) e = {e[DOW-9:0], 8'(seed + 8'(8 * w + b))};
    return e;
  endfunction

  task automatic test_reset();
    logic [80:0] exp;
    sink_valid = 1'b1;
    sink_startofpacket = 1'b1;
    sink_data = mk_data(8'h55);
    @(negedge clk); #1;
    n_cmp++;
    if (obs !== 81'd0) begin
      n_err++; $display("FAIL reset_outputs got=%h exp=%h", obs, 81'd0);
    end
    sink_valid = 1'b0;
    sink_startofpacket = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    exp = {1'b0, 1'b0, 1'b0, 3'd0, 10'd0, 64'd0, 1'b1};
    n_cmp++;
    if (obs !== exp) begin
      n_err++; $display("FAIL post_reset_idle got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_single_beat();
    logic [63:0] w_exp [4] = '{64'h0001020304050607, 64'h08090A0B0C0D0E0F,
                               64'h1011121314151617, 64'h18191A1B1C1D1E1F};
    logic [80:0] exp;
    @(negedge clk);
    source_ready = 1'b1;
    sink_valid = 1'b1; sink_data = mk_data(8'h00);
    sink_startofpacket = 1'b1; sink_endofpacket = 1'b1; sink_empty = 5'd0; sink_channel = 10'h005;
    #1;
    n_cmp++;
    if (sink_ready !== 1'b1) begin
      n_err++; $display("FAIL single_idle_ready got=%b exp=1", sink_ready);
    end
    @(negedge clk);
    sink_valid = 1'b0; sink_startofpacket = 1'b0; sink_endofpacket = 1'b0;
    for (int w = 0; w < 4; w++) begin
      #1;
      exp = {1'b1, w == 0, w == 3, 3'd0, 10'h005, w_exp[w], w == 3};
      n_cmp++;
      if (obs !== exp) begin
        n_err++; $display("FAIL single_w%0d got=%h exp=%h", w, obs, exp);
      end
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if (source_valid !== 1'b0) begin
      n_err++; $display("FAIL single_drain got=%b exp=0", source_valid);
    end
  endtask

  task automatic test_eop_empty();
    logic [63:0] w_exp [3] = '{64'h4041424344454647, 64'h48494A4B4C4D4E4F, 64'h5051525354555657};
    logic [80:0] exp;
    @(negedge clk);
    sink_valid = 1'b1; sink_data = mk_data(8'h40);
    sink_startofpacket = 1'b1; sink_endofpacket = 1'b1; sink_empty = 5'd13; sink_channel = 10'h0F0;
    @(negedge clk);
    sink_valid = 1'b0; sink_startofpacket = 1'b0; sink_endofpacket = 1'b0; sink_empty = 5'd0;
    for (int w = 0; w < 3; w++) begin
      #1;
      exp = {1'b1, w == 0, w == 2, (w == 2) ? 3'd5 : 3'd0, 10'h0F0, w_exp[w], w == 2};
      n_cmp++;
      if (obs !== exp) begin
        n_err++; $display("FAIL empty13_w%0d got=%h exp=%h", w, obs, exp);
      end
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if (source_valid !== 1'b0) begin
      n_err++; $display("FAIL empty13_drain got=%b exp=0", source_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  seeds [3] = '{8'h80, 8'hA0, 8'hC0};
    logic [80:0] exp;
    int          bi = 0;
    int          k;
    for (int cyc = 0; cyc < 13; cyc++) begin
      @(negedge clk);
      if (bi < 3) begin
        sink_valid = 1'b1; sink_data = mk_data(seeds[bi]);
        sink_startofpacket = (bi == 0); sink_endofpacket = (bi == 2);
        sink_empty = 5'd0; sink_channel = 10'h011;
      end else begin
        sink_valid = 1'b0; sink_startofpacket = 1'b0; sink_endofpacket = 1'b0;
      end
      #1;
      if (cyc == 0) begin
        exp = {1'b0, 1'b0, 1'b0, 3'd0, 10'd0, 64'd0, 1'b1};
      end else begin
        k = cyc - 1;
        exp = {1'b1, k == 0, k == 11, 3'd0, 10'h011, exp_bytes(seeds[k / 4], k % 4), (k % 4) == 3};
      end
      n_cmp++;
      if (obs !== exp) begin
        n_err++; $display("FAIL b2b_cyc%0d got=%h exp=%h", cyc, obs, exp);
      end
      if (sink_valid && sink_ready) bi++;
    end
    @(negedge clk);
    sink_valid = 1'b0;
    #1;
    n_cmp++;
    if (source_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_drain got=%b exp=0", source_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0]  seeds [2] = '{8'h10, 8'h30};
    logic [79:0] prev = '0;
    logic [74:0] exp;
    logic        stalled = 1'b0;
    int          got = 0;
    int          bi = 0;
    for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
      @(negedge clk);
      source_ready = 1'($urandom_range(0, 1));
      if (bi < 2) begin
        sink_valid = 1'b1; sink_data = mk_data(seeds[bi]);
        sink_startofpacket = (bi == 0); sink_endofpacket = (bi == 1);
        sink_empty = 5'd0; sink_channel = 10'h155;
      end else begin
        sink_valid = 1'b0; sink_startofpacket = 1'b0; sink_endofpacket = 1'b0;
      end
      #1;
      if (stalled) begin
        n_cmp++;
        if (obs[80:1] !== prev) begin
          n_err++; $display("FAIL bp_stable_cyc%0d got=%h exp=%h", cyc, obs[80:1], prev);
        end
      end
      if (source_valid) begin
        exp = {got == 7, 10'h155, exp_bytes(seeds[got / 4], got % 4)};
        n_cmp++;
        if ({source_endofpacket, source_channel, source_data} !== exp) begin
          n_err++; $display("FAIL bp_word%0d got=%h exp=%h", got,
                            {source_endofpacket, source_channel, source_data}, exp);
        end
      end
      stalled = source_valid && !source_ready;
      prev = obs[80:1];
      if (source_valid && source_ready) got++;
      if (sink_valid && sink_ready) bi++;
    end
    n_cmp++;
    if (got !== 8) begin
      n_err++; $display("FAIL bp_count got=%0d exp=8", got);
    end
    @(negedge clk);
    sink_valid = 1'b0; source_ready = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_channel();
    logic [9:0] chans [2] = '{10'h2A5, 10'h013};
    int         bi = 0;
    int         k;
    for (int cyc = 0; cyc < 9; cyc++) begin
      @(negedge clk);
      if (bi < 2) begin
        sink_valid = 1'b1; sink_data = mk_data(8'(8'h20 * bi));
        sink_startofpacket = (bi == 0); sink_endofpacket = (bi == 1);
        sink_empty = 5'd0; sink_channel = chans[bi];
      end else begin
        sink_valid = 1'b0; sink_startofpacket = 1'b0; sink_endofpacket = 1'b0;
      end
      #1;
      if (cyc > 0) begin
        k = cyc - 1;
        n_cmp++;
        if ({source_valid, source_channel} !== {1'b1, chans[k / 4]}) begin
          n_err++; $display("FAIL chan_w%0d got=%h exp=%h", k, {source_valid, source_channel},
                            {1'b1, chans[k / 4]});
        end
      end
      if (sink_valid && sink_ready) bi++;
    end
    @(negedge clk);
    sink_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_packet();
    logic [80:0] exp;
    @(negedge clk);
    sink_valid = 1'b1; sink_data = mk_data(8'h60);
    sink_startofpacket = 1'b1; sink_endofpacket = 1'b0; sink_empty = 5'd0; sink_channel = 10'h003;
    @(negedge clk);
    sink_valid = 1'b0; sink_startofpacket = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if (source_data !== exp_bytes(8'h60, 1)) begin
      n_err++; $display("FAIL rst_pre_word1 got=%h exp=%h", source_data, exp_bytes(8'h60, 1));
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 81'd0) begin
      n_err++; $display("FAIL rst_async_clear got=%h exp=%h", obs, 81'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    sink_valid = 1'b1; sink_data = mk_data(8'h70);
    sink_startofpacket = 1'b1; sink_endofpacket = 1'b1; sink_channel = 10'h007;
    #1;
    n_cmp++;
    if (sink_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_restart_ready got=%b exp=1", sink_ready);
    end
    @(negedge clk);
    sink_valid = 1'b0; sink_startofpacket = 1'b0; sink_endofpacket = 1'b0;
    #1;
    exp = {1'b1, 1'b1, 1'b0, 3'd0, 10'h007, exp_bytes(8'h70, 0), 1'b0};
    n_cmp++;
    if (obs !== exp) begin
      n_err++; $display("FAIL rst_restart_w0 got=%h exp=%h", obs, exp);
    end
    repeat (4) @(negedge clk);
`ifdef AST_WIDTH_REDUCER_PROTO_CHECK_EN
    #1;
    n_cmp++;
    if (proto_err !== 1'b0) begin
      n_err++; $display("FAIL proto_clean got=%b exp=0", proto_err);
    end
    @(negedge clk);
    sink_valid = 1'b1; sink_data = mk_data(8'h00);
    sink_startofpacket = 1'b0; sink_endofpacket = 1'b1;
    @(negedge clk);
    sink_valid = 1'b0; sink_endofpacket = 1'b0;
    #1;
    n_cmp++;
    if (proto_err !== 1'b1) begin
      n_err++; $display("FAIL proto_no_sop got=%b exp=1", proto_err);
    end
    repeat (5) @(negedge clk);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_beat();
    test_eop_empty();
    test_back_to_back();
    test_backpressure();
    test_channel();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
